reg_writeback_queue: RTL and testbench

Writer side of the 32x32 register-file write port (reg_write / write_reg / write_data). Accepts results from two producers, the ALU and load return, over valid/ready handshakes. Load data is aligned and extended before the result is buffered in a small in-order queue. One write per cycle is then drained into the register file, and the youngest pending value for any register is exposed for operand forwarding.

---
 rtl/reg_writeback_queue.sv | 97 +++++++++
 tb/tb_reg_writeback_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order writeback queue feeding the 32x32 register-file write port
//   alu_*  : ALU result handshake (load has priority)
//   ld_*   : load result handshake; raw word is aligned/extended by size and address
//   wb_hold: stalls the drain into the registered reg_write/write_reg/write_data
//   fwd_*  : youngest pending value for two operand registers
//   busy   : queue non-empty or a write in flight
module reg_writeback_queue #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_rdata,
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic        wb_hold,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  input  logic [4:0]  fwd_reg1,
  input  logic [4:0]  fwd_reg2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2,
  output logic        busy
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL = QDEPTH[PW:0];
  logic [4:0] q_rd [QDEPTH];
  logic [31:0] q_data [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic full, acc_ld, acc_alu, enq, deq;
  logic [4:0] in_rd;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val, in_data;
  assign full = count == FULL;
  assign ld_ready = rst_n && !full;
  assign alu_ready = rst_n && !full && !ld_valid;
  assign acc_ld = ld_valid && ld_ready;
  assign acc_alu = alu_valid && alu_ready;
  assign ld_b = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
  assign ld_h = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
  assign ld_val = ld_size == 2'b00 ? {{24{!ld_unsigned && ld_b[7]}}, ld_b}
                : ld_size == 2'b01 ? {{16{!ld_unsigned && ld_h[15]}}, ld_h} : ld_rdata;
  assign in_rd = acc_ld ? ld_rd : alu_rd;
  assign in_data = acc_ld ? ld_val : alu_data;
  // x0 writes complete the handshake but are never stored
  assign enq = (acc_ld || acc_alu) && in_rd != 5'd0;
  assign deq = count != '0 && !wb_hold;
  assign busy = count != '0 || reg_write;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      reg_write <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(enq) - (PW+1)'(deq);
      reg_write <= deq;
      if (deq) begin
        write_reg <= q_rd[rd_ptr];
        write_data <= q_data[rd_ptr];
      end
    end
  always_ff @(posedge clk)
    if (enq) begin
      q_rd[wr_ptr] <= in_rd;
      q_data[wr_ptr] <= in_data;
    end
  // Scan oldest to newest so the last match (youngest) wins; output register is oldest of all
  function automatic logic [32:0] lookup(input logic [4:0] r);
    logic [32:0] res;
    logic [PW-1:0] idx;
    res = (reg_write && write_reg == r) ? {1'b1, write_data} : 33'd0;
    for (int i = 0; i < QDEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((PW+1)'(i) < count && q_rd[idx] == r) res = {1'b1, q_data[idx]};
    end
    return r == 5'd0 ? 33'd0 : res;
  endfunction
  assign {fwd_hit1, fwd_data1} = lookup(fwd_reg1);
  assign {fwd_hit2, fwd_data2} = lookup(fwd_reg2);
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed self-checking bench for reg_writeback_queue
module tb_reg_writeback_queue;
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_valid = 1'b0, ld_valid = 1'b0, ld_unsigned = 1'b0, wb_hold = 1'b0;
  logic [4:0] alu_rd = '0, ld_rd = '0, fwd_reg1 = '0, fwd_reg2 = '0;
  logic [31:0] alu_data = '0, ld_rdata = '0;
  logic [1:0] ld_addr_lo = '0, ld_size = '0;
  logic alu_ready, ld_ready, reg_write, fwd_hit1, fwd_hit2, busy;
  logic [4:0] write_reg;
  logic [31:0] write_data, fwd_data1, fwd_data2;
  int checks = 0, errors = 0;

  reg_writeback_queue #(.QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_rdata(ld_rdata),
    .ld_addr_lo(ld_addr_lo), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .wb_hold(wb_hold), .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ld_case(input logic [1:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] exp, input string tag);
    ld_valid = 1'b1; ld_rd = 5'd6; ld_rdata = 32'h80F1_7F82;
    ld_addr_lo = addr; ld_size = size; ld_unsigned = uns;
    #1 chk({tag, "_ld_ready"}, ld_ready, 1);
    tick;
    ld_valid = 1'b0; fwd_reg1 = 5'd6;
    #1 chk({tag, "_fwd"}, fwd_data1, exp);
    tick;
    chk({tag, "_wreg"}, write_reg, 6);
    chk({tag, "_wdata"}, write_data, exp);
  endtask

  task automatic alu_put(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    #1 chk("hold_fill_ready", alu_ready, 1);
    tick;
  endtask

  initial begin
    #12;
    chk("rst_reg_write", reg_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    rst_n = 1'b1;
    tick;
    // single ALU write with forwarding window
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; fwd_reg1 = 5'd5;
    #1 chk("alu_ready", alu_ready, 1);
    tick;
    alu_valid = 1'b0;
    #1 chk("alu_fwd_hit_q", fwd_hit1, 1);
    chk("alu_fwd_data_q", fwd_data1, 32'hDEADBEEF);
    chk("alu_no_write_yet", reg_write, 0);
    chk("alu_busy", busy, 1);
    tick;
    chk("alu_reg_write", reg_write, 1);
    chk("alu_write_reg", write_reg, 5);
    chk("alu_write_data", write_data, 32'hDEADBEEF);
    chk("alu_fwd_hit_out", fwd_hit1, 1);
    tick;
    chk("alu_write_drop", reg_write, 0);
    chk("alu_fwd_gone", fwd_hit1, 0);
    chk("alu_fwd_zero", fwd_data1, 0);
    chk("alu_data_hold", write_data, 32'hDEADBEEF);
    chk("alu_idle", busy, 0);
    // load alignment
    ld_case(2'd3, 2'b00, 1'b0, 32'hFFFFFF80, "ld_b3s");
    ld_case(2'd1, 2'b00, 1'b1, 32'h0000007F, "ld_b1u");
    ld_case(2'd2, 2'b01, 1'b0, 32'hFFFF80F1, "ld_h2s");
    ld_case(2'd1, 2'b01, 1'b1, 32'h00007F82, "ld_h1u");
    ld_case(2'd0, 2'b10, 1'b0, 32'h80F17F82, "ld_w");
    tick;
    // arbitration: load wins, ALU next cycle
    ld_valid = 1'b1; ld_rd = 5'd3; ld_rdata = 32'h33; ld_size = 2'b10;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    #1 chk("arb_ld_ready", ld_ready, 1);
    chk("arb_alu_blocked", alu_ready, 0);
    tick;
    ld_valid = 1'b0;
    #1 chk("arb_alu_ready", alu_ready, 1);
    tick;
    alu_valid = 1'b0;
    chk("arb_w1_reg", write_reg, 3);
    chk("arb_w1_data", write_data, 32'h33);
    tick;
    chk("arb_w2_en", reg_write, 1);
    chk("arb_w2_reg", write_reg, 4);
    chk("arb_w2_data", write_data, 32'h44);
    tick;
    chk("arb_done", reg_write, 0);
    // hold, fill, stall, release
    wb_hold = 1'b1;
    alu_put(5'd1, 32'd10);
    alu_put(5'd2, 32'd20);
    alu_put(5'd3, 32'd30);
    alu_put(5'd4, 32'd40);
    alu_rd = 5'd2; alu_data = 32'd99; fwd_reg1 = 5'd2; fwd_reg2 = 5'd4;
    #1 chk("full_alu_ready", alu_ready, 0);
    chk("full_ld_ready", ld_ready, 0);
    chk("hold_no_write", reg_write, 0);
    chk("hold_fwd_x2", fwd_data1, 32'd20);
    chk("hold_fwd_x4", fwd_data2, 32'd40);
    tick;
    chk("stall_alu_ready", alu_ready, 0);
    wb_hold = 1'b0;
    tick;
    chk("rel_w1_reg", write_reg, 1);
    chk("rel_w1_data", write_data, 32'd10);
    chk("rel_alu_ready", alu_ready, 1);
    tick;
    alu_valid = 1'b0;
    chk("rel_w2_reg", write_reg, 2);
    chk("rel_w2_data", write_data, 32'd20);
    #1 chk("rel_fwd_young", fwd_data1, 32'd99);
    tick;
    chk("rel_w3_data", write_data, 32'd30);
    tick;
    chk("rel_w4_data", write_data, 32'd40);
    tick;
    chk("rel_w5_en", reg_write, 1);
    chk("rel_w5_reg", write_reg, 2);
    chk("rel_w5_data", write_data, 32'd99);
    tick;
    chk("rel_done", busy, 0);
    // x0 destination
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234; fwd_reg1 = 5'd0;
    #1 chk("x0_ready", alu_ready, 1);
    tick;
    alu_valid = 1'b0;
    chk("x0_busy", busy, 0);
    chk("x0_fwd_hit", fwd_hit1, 0);
    chk("x0_fwd_data", fwd_data1, 0);
    tick;
    chk("x0_no_write", reg_write, 0);
    chk("x0_busy2", busy, 0);
    // asynchronous reset with 3 entries queued and a write in flight
    wb_hold = 1'b1;
    alu_put(5'd7, 32'd7);
    alu_put(5'd8, 32'd8);
    alu_put(5'd9, 32'd9);
    alu_put(5'd10, 32'd10);
    alu_valid = 1'b0; wb_hold = 1'b0;
    tick;
    fwd_reg1 = 5'd8; fwd_reg2 = 5'd7;
    #1 chk("pre_rst_write", reg_write, 1);
    chk("pre_rst_fwd", fwd_hit1, 1);
    rst_n = 1'b0;
    #1 chk("mid_rst_write", reg_write, 0);
    chk("mid_rst_wreg", write_reg, 0);
    chk("mid_rst_wdata", write_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hit1", fwd_hit1, 0);
    chk("mid_rst_hit2", fwd_hit2, 0);
    chk("mid_rst_data1", fwd_data1, 0);
    chk("mid_rst_alu_ready", alu_ready, 0);
    chk("mid_rst_ld_ready", ld_ready, 0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("post_rst_no_write", reg_write, 0);
      chk("post_rst_busy", busy, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
